core_launcher: RTL

Host-side initiator for the processor core's req/done handshake. It streams a job's input bytes into data memory, holds the core in reset, and pulses req. It then waits for done under a cycle timeout and streams result bytes back out of data memory. It sits beside the core at system level and owns the data-memory port via mem_own while loading and reading back.

---
 rtl/core_launcher_pkg.sv | 10 +
 rtl/core_launcher_if.sv | 36 +++
 rtl/core_launcher_cycle_ctr.sv | 26 ++
 rtl/core_launcher.sv | 124 ++++++++++++
 4 files changed

// File: rtl/core_launcher_pkg.sv
// Shared definitions for the core launcher: FSM state encoding, the
// data-memory address width and the core-reset dwell length.
package core_launch_pkg;
   localparam int AW          = 8;  // data-memory address width
   localparam int RSTC_CYCLES = 2;  // cycles core_reset is held after preload

   typedef enum logic [2:0] {
      IDLE, LOAD, RSTC, REQ, RUN, READ, FIN
   } state_e;
endpackage

// File: rtl/core_launcher_if.sv
// Handshake/bus bundle between the launcher and its environment.
//   ld_*   : preload byte stream into the launcher (valid/ready)
//   core_* : core_reset/req out to the core, done back from it
//   mem_*  : data-memory port (combinational read data)
//   res_*  : result byte stream out of the launcher (valid/ready)
// master = launcher side, slave = host/core/memory side.
interface core_launcher_if;
   import core_launch_pkg::*;

   logic          ld_valid;
   logic [7:0]    ld_data;
   logic          ld_ready;
   logic          core_reset;
   logic          req;
   logic          done;
   logic          mem_own;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wr_dat;
   logic [7:0]    mem_rd_dat;
   logic          res_valid;
   logic [7:0]    res_data;
   logic          res_ready;

   modport master (
      input  ld_valid, ld_data, done, mem_rd_dat, res_ready,
      output ld_ready, core_reset, req, mem_own, mem_wr_en, mem_addr,
             mem_wr_dat, res_valid, res_data
   );

   modport slave (
      output ld_valid, ld_data, done, mem_rd_dat, res_ready,
      input  ld_ready, core_reset, req, mem_own, mem_wr_en, mem_addr,
             mem_wr_dat, res_valid, res_data
   );
endinterface

// File: rtl/core_launcher_cycle_ctr.sv
// launch_cycle_ctr: clearable, saturating up-counter with enable.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable; the count sticks at all-ones
//   cnt        : current count
//   at_limit   : cnt equals LIMIT
module launch_cycle_ctr #(
   parameter int          CW    = 16,
   parameter int unsigned LIMIT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          at_limit
);
   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + CW'(1);
   end

   assign at_limit = (cnt == CW'(LIMIT));
endmodule

// File: rtl/core_launcher.sv
// core_launcher: host-side initiator for the core req/done handshake.
// Preloads LD_LEN bytes into data memory, holds the core in reset for
// RSTC_CYCLES, pulses req, waits for done (aborting after TIMEOUT RUN
// cycles) and streams RES_LEN result bytes back out.
//   clk, reset        : clock, synchronous active-high reset
//   start             : launch a job (honoured in IDLE only)
//   bus (master)      : preload stream, core handshake, memory port, results
//   busy              : not IDLE
//   job_done          : one-cycle pulse on successful completion
//   timeout           : sticky abort flag, cleared by the next accepted start
//   cycles            : RUN cycle count of the last job
module core_launcher
   import core_launch_pkg::*;
#(
   parameter int LD_BASE  = 0,
   parameter int LD_LEN   = 8,
   parameter int RES_BASE = 64,
   parameter int RES_LEN  = 8,
   parameter int TIMEOUT  = 4095,
   parameter int CW       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   core_launcher_if.master  bus,
   output logic             busy,
   output logic             job_done,
   output logic             timeout,
   output logic [CW-1:0]    cycles
);
   // idx is one bit wider than the address so a 256-byte transfer can
   // reach its last index without wrapping into the compare.
   localparam int            IW       = AW + 1;
   localparam logic [IW-1:0] LD_LAST  = IW'(LD_LEN - 1);
   localparam logic [IW-1:0] RES_LAST = IW'(RES_LEN - 1);

   state_e        state, nxt;
   logic [IW-1:0] idx;
   logic          ld_beat, res_beat;
   logic          run_lim, dwell_lim;
   logic [1:0]    dwell_cnt_unused;

   assign ld_beat  = (state == LOAD) && bus.ld_valid;
   assign res_beat = bus.res_valid && bus.res_ready;

   launch_cycle_ctr #(.CW(CW), .LIMIT(TIMEOUT)) u_run_ctr (
      .clk      (clk),
      .reset    (reset),
      .clr      ((state == IDLE) && start),
      .en       (state == RUN),
      .cnt      (cycles),
      .at_limit (run_lim)
   );

   // Dwell counter sits at zero outside RSTC, so RSTC lasts LIMIT+1 cycles.
   launch_cycle_ctr #(.CW(2), .LIMIT(RSTC_CYCLES - 1)) u_dwell_ctr (
      .clk      (clk),
      .reset    (reset),
      .clr      (state != RSTC),
      .en       (state == RSTC),
      .cnt      (dwell_cnt_unused),
      .at_limit (dwell_lim)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = (LD_LEN == 0) ? RSTC : LOAD;
         LOAD: if (ld_beat && (idx == LD_LAST)) nxt = RSTC;
         RSTC: if (dwell_lim) nxt = REQ;
         REQ:  nxt = RUN;
         // done beats the timeout when both land in the same cycle
         RUN:  if (bus.done)    nxt = (RES_LEN == 0) ? FIN : READ;
               else if (run_lim) nxt = IDLE;
         READ: if (res_beat && (idx == RES_LAST)) nxt = FIN;
         FIN:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // State, index and all state-derived outputs are registered from nxt,
   // so they change together on the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         timeout        <= 1'b0;
         busy           <= 1'b0;
         job_done       <= 1'b0;
         bus.core_reset <= 1'b1;
         bus.req        <= 1'b0;
         bus.ld_ready   <= 1'b0;
         bus.mem_own    <= 1'b0;
         bus.res_valid  <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (start) begin
               idx     <= '0;
               timeout <= 1'b0;
            end
            LOAD: if (ld_beat) idx <= idx + IW'(1);
            RUN:  if (bus.done) idx <= '0;
                  else if (run_lim) timeout <= 1'b1;
            READ: if (res_beat) idx <= idx + IW'(1);
            default: ;
         endcase
         busy           <= (nxt != IDLE);
         job_done       <= (nxt == FIN);
         // core stays in reset while memory is being preloaded
         bus.core_reset <= (nxt == IDLE) || (nxt == LOAD) || (nxt == RSTC);
         bus.req        <= (nxt == REQ);
         bus.ld_ready   <= (nxt == LOAD);
         bus.mem_own    <= (nxt == LOAD) || (nxt == READ);
         bus.res_valid  <= (nxt == READ);
      end
   end

   assign bus.mem_wr_en  = ld_beat;
   assign bus.mem_wr_dat = (state == LOAD) ? bus.ld_data : '0;
   assign bus.mem_addr   = (state == LOAD) ? AW'(LD_BASE)  + idx[AW-1:0] :
                           (state == READ) ? AW'(RES_BASE) + idx[AW-1:0] : '0;
   assign bus.res_data   = (state == READ) ? bus.mem_rd_dat : '0;
endmodule
